fifo_banked: RTL and testbench

FIFO_BANKED -- requirements
Module: fifo_banked

---
 rtl/fifo_banked.sv | 135 +++++++++++++
 tb/tb_fifo_banked.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_banked.sv
// Banked FIFO: NUM_BANKS independent memories presented as one ordered FIFO of NUM_BANKS*BANK_DEPTH words.
// Optional occupancy/almost-full outputs are enabled by defining FIFO_BANKED_LEVEL_EN.
module fifo_banked #(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_DEPTH = 2048,
    parameter int NUM_BANKS  = 2,
    parameter int AF_THRESH  = NUM_BANKS * BANK_DEPTH - 4,
    localparam int DEPTH     = NUM_BANKS * BANK_DEPTH,
    localparam int AW        = $clog2(BANK_DEPTH),
    localparam int SW        = $clog2(NUM_BANKS),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [SW-1:0]         wr_bank,
    output logic [SW-1:0]         rd_bank,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_BANKED_LEVEL_EN
    ,
    output logic [CW-1:0]         level,
    output logic                  almost_full
`endif
);

    localparam logic [SW-1:0] LAST_BANK = SW'(NUM_BANKS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BANK_DEPTH - 1);

    // Reject illegal configurations at elaboration rather than building a broken FIFO.
    if (NUM_BANKS < 2 || NUM_BANKS > 16) begin : g_bad_banks
        $error("fifo_banked: NUM_BANKS must be in 2..16");
    end
    if (BANK_DEPTH < 2 || (BANK_DEPTH & (BANK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_banked: BANK_DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_banked: AF_THRESH must be in 0..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [SW+AW-1:0]      wr_ptr_nxt;
    logic [SW+AW-1:0]      rd_ptr_nxt;

    // Address walks through a bank, then the bank index advances with no idle cycle.
    function automatic logic [SW+AW-1:0] ptr_inc(input logic [SW-1:0] bank,
                                                 input logic [AW-1:0] addr);
        logic [SW-1:0] bank_nxt;
        if (addr == LAST_ADDR) begin
            bank_nxt = (bank == LAST_BANK) ? '0 : bank + 1'b1;
            return {bank_nxt, {AW{1'b0}}};
        end
        return {bank, addr + 1'b1};
    endfunction

    assign wr_ok      = wr && !full;
    assign rd_ok      = rd && !empty;
    assign wr_ptr_nxt = ptr_inc(wr_bank, wr_addr);
    assign rd_ptr_nxt = ptr_inc(rd_bank, rd_addr);

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Bank storage is never reset; a reset only discards the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_bank][wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank   <= '0;
            wr_addr   <= '0;
            rd_bank   <= '0;
            rd_addr   <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                data_out           <= mem[rd_bank][rd_addr];
                {rd_bank, rd_addr} <= rd_ptr_nxt;
            end
            if (wr_ok) begin
                {wr_bank, wr_addr} <= wr_ptr_nxt;
            end
            if (wr && full) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

`ifdef FIFO_BANKED_LEVEL_EN
    assign level = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_nxt >= CW'(AF_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_banked.sv
// Bench for fifo_banked (3 banks x 4 words): directed scenarios then random traffic against a queue model.
module tb_fifo_banked;

    localparam int DW    = 16;
    localparam int BD    = 4;
    localparam int NB    = 3;
    localparam int AFT   = 10;
    localparam int DEPTH = NB * BD;
    localparam int SW    = $clog2(NB);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic [DW-1:0] data_in;
    logic          rd;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [SW-1:0] wr_bank;
    logic [SW-1:0] rd_bank;
    logic          overflow;
    logic          underflow;
`ifdef FIFO_BANKED_LEVEL_EN
    logic [CW-1:0] level;
    logic          almost_full;
`endif

    always #5 clk = ~clk;

    fifo_banked #(
        .DATA_WIDTH(DW),
        .BANK_DEPTH(BD),
        .NUM_BANKS (NB),
        .AF_THRESH (AFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .data_in  (data_in),
        .rd       (rd),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .wr_bank  (wr_bank),
        .rd_bank  (rd_bank),
        .overflow (overflow),
        .underflow(underflow)
`ifdef FIFO_BANKED_LEVEL_EN
        ,
        .level      (level),
        .almost_full(almost_full)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored words plus the count of accepted writes/reads modulo DEPTH.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_unf;
    int            wr_idx;
    int            rd_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        wr_idx    = 0;
        rd_idx    = 0;
    endtask

    task automatic check_all();
        chk("data_out",  32'(data_out),  32'(exp_data));
        chk("rd_valid",  32'(rd_valid),  32'(exp_valid));
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("full",      32'(full),      32'(q.size() == DEPTH));
        chk("wr_bank",   32'(wr_bank),   32'(wr_idx / BD));
        chk("rd_bank",   32'(rd_bank),   32'(rd_idx / BD));
        chk("overflow",  32'(overflow),  32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_unf));
`ifdef FIFO_BANKED_LEVEL_EN
        chk("level",       32'(level),       32'(q.size()));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AFT));
`endif
    endtask

    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        logic wr_ok;
        logic rd_ok;
        wr      = w;
        rd      = r;
        data_in = d;
        wr_ok   = w && (q.size() != DEPTH);
        rd_ok   = r && (q.size() != 0);
        if (w && !wr_ok) exp_ovf = 1'b1;
        if (r && !rd_ok) exp_unf = 1'b1;
        exp_valid = rd_ok;
        if (rd_ok) begin
            exp_data = q.pop_front();
            rd_idx   = (rd_idx + 1) % DEPTH;
        end
        if (wr_ok) begin
            q.push_back(d);
            wr_idx = (wr_idx + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        check_all();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        #1 rst = 1'b0;

        // Fill with 1..12 across all three banks.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));

        // Write while full is dropped; overflow stays set.
        cycle(1'b1, 1'b0, 16'hDEAD);
        cycle(1'b0, 1'b0, 16'h0000);

        // Drain: 1..12 in order, then data_out holds.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);

        // Read while empty.
        cycle(1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);

        // Prefill 5 then 20 cycles of concurrent read and write.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(16'h0100 + i));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, DW'(16'h0200 + i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0000);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, DW'(16'h0300 + i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0000);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b0;
        cycle(1'b1, 1'b0, 16'hBEEF);
        cycle(1'b0, 1'b1, 16'h0000);
        chk("post_reset_word", 32'(data_out), 32'h0000BEEF);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
